axis_slave_mem: RTL



---
 rtl/axis_slave_mem_pkg.sv | 27 ++
 rtl/axis_slave_ram.sv | 53 +++++
 rtl/axis_slave_mem.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/axis_slave_mem_pkg.sv
// ============================================================================
// Module : axis_slave_mem_pkg
// Brief  : Shared response codes and FSM state encodings for axis_slave_mem.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package axis_slave_mem_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_DATA = 2'd1,
        W_RESP = 2'd2
    } wr_state_t;

    typedef enum logic [1:0] {
        R_IDLE  = 2'd0,
        R_FETCH = 2'd1,
        R_DATA  = 2'd2
    } rd_state_t;

endpackage

`default_nettype wire

// File: rtl/axis_slave_ram.sv
// ============================================================================
// Module : axis_slave_ram
// Brief  : Simple dual-port RAM, byte-enabled write port, registered read-first
//          read port whose output register holds when no read is requested.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module axis_slave_ram #(
    parameter int MEM_AWIDTH     = 10,
    parameter int AXI_DATA_WIDTH = 256
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        we_i,
    input  logic [MEM_AWIDTH-1:0]       waddr_i,
    input  logic [AXI_DATA_WIDTH-1:0]   wdata_i,
    input  logic [AXI_DATA_WIDTH/8-1:0] wstrb_i,
    input  logic                        re_i,
    input  logic [MEM_AWIDTH-1:0]       raddr_i,
    output logic [AXI_DATA_WIDTH-1:0]   rdata_o
);

    localparam int BL    = AXI_DATA_WIDTH / 8;
    localparam int DEPTH = 1 << MEM_AWIDTH;

    logic [AXI_DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [AXI_DATA_WIDTH-1:0] rdata_q;

    // Contents are deliberately not reset so data survives a bus reset.
    always_ff @(posedge clk) begin
        if (we_i) begin
            for (int b = 0; b < BL; b++) begin
                if (wstrb_i[b]) begin
                    mem_q[waddr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

`default_nettype wire

// File: rtl/axis_slave_mem.sv
// ============================================================================
// Module : axis_slave_mem
// Brief  : AXI memory-mapped responder for INCR bursts, backed by on-chip RAM;
//          independent write and read FSMs.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module axis_slave_mem
    import axis_slave_mem_pkg::*;
#(
    parameter int MEM_AWIDTH     = 10,
    parameter int AXI_ID_WIDTH   = 8,
    parameter int AXI_LEN_WIDTH  = 8,
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int AXI_DATA_WIDTH = 256
) (
    input  logic                        clk,
    input  logic                        rst,
    output logic                        axi_awready_o,
    input  logic [AXI_ID_WIDTH-1:0]     axi_awid_i,
    input  logic [AXI_ADDR_WIDTH-1:0]   axi_awaddr_i,
    input  logic [AXI_LEN_WIDTH-1:0]    axi_awlen_i,
    input  logic                        axi_awvalid_i,
    output logic                        axi_wready_o,
    input  logic [AXI_DATA_WIDTH-1:0]   axi_wdata_i,
    input  logic [AXI_DATA_WIDTH/8-1:0] axi_wstrb_i,
    input  logic                        axi_wlast_i,
    input  logic                        axi_wvalid_i,
    output logic [AXI_ID_WIDTH-1:0]     axi_bid_o,
    output logic [1:0]                  axi_bresp_o,
    output logic                        axi_bvalid_o,
    input  logic                        axi_bready_i,
    output logic                        axi_arready_o,
    input  logic [AXI_ID_WIDTH-1:0]     axi_arid_i,
    input  logic [AXI_ADDR_WIDTH-1:0]   axi_araddr_i,
    input  logic [AXI_LEN_WIDTH-1:0]    axi_arlen_i,
    input  logic                        axi_arvalid_i,
    output logic [AXI_ID_WIDTH-1:0]     axi_rid_o,
    output logic [1:0]                  axi_rresp_o,
    output logic [AXI_DATA_WIDTH-1:0]   axi_rdata_o,
    output logic                        axi_rlast_o,
    output logic                        axi_rvalid_o,
    input  logic                        axi_rready_i
);

    localparam int BS = $clog2(AXI_DATA_WIDTH / 8);
    localparam logic [MEM_AWIDTH-1:0]    ADDR_ONE = {{(MEM_AWIDTH-1){1'b0}}, 1'b1};
    localparam logic [AXI_LEN_WIDTH-1:0] LEN_ONE  = {{(AXI_LEN_WIDTH-1){1'b0}}, 1'b1};

    // ---------------------------------------------------------------- write
    wr_state_t                 wr_state_q, wr_state_d;
    logic [AXI_ID_WIDTH-1:0]   wr_id_q, wr_id_d;
    logic [MEM_AWIDTH-1:0]     wr_addr_q, wr_addr_d;
    logic [AXI_LEN_WIDTH-1:0]  wr_cnt_q, wr_cnt_d;
    logic                      wr_err_q, wr_err_d;
    logic                      ram_we;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_state_q <= W_IDLE;
            wr_id_q    <= '0;
            wr_addr_q  <= '0;
            wr_cnt_q   <= '0;
            wr_err_q   <= 1'b0;
        end else begin
            wr_state_q <= wr_state_d;
            wr_id_q    <= wr_id_d;
            wr_addr_q  <= wr_addr_d;
            wr_cnt_q   <= wr_cnt_d;
            wr_err_q   <= wr_err_d;
        end
    end

    always_comb begin
        wr_state_d = wr_state_q;
        wr_id_d    = wr_id_q;
        wr_addr_d  = wr_addr_q;
        wr_cnt_d   = wr_cnt_q;
        wr_err_d   = wr_err_q;
        case (wr_state_q)
            W_IDLE: begin
                if (axi_awvalid_i) begin
                    wr_id_d    = axi_awid_i;
                    wr_addr_d  = axi_awaddr_i[MEM_AWIDTH+BS-1:BS];
                    wr_cnt_d   = axi_awlen_i;
                    wr_err_d   = 1'b0;
                    wr_state_d = W_DATA;
                end
            end
            W_DATA: begin
                // The beat count, not wlast, ends the burst; a misplaced wlast only flags an error.
                if (axi_wvalid_i) begin
                    wr_addr_d = wr_addr_q + ADDR_ONE;
                    wr_cnt_d  = wr_cnt_q - LEN_ONE;
                    if (axi_wlast_i != (wr_cnt_q == '0)) begin
                        wr_err_d = 1'b1;
                    end
                    if (wr_cnt_q == '0) begin
                        wr_state_d = W_RESP;
                    end
                end
            end
            W_RESP: begin
                if (axi_bready_i) begin
                    wr_state_d = W_IDLE;
                end
            end
            default: wr_state_d = W_IDLE;
        endcase
    end

    always_comb begin
        axi_awready_o = !rst && (wr_state_q == W_IDLE);
        axi_wready_o  = (wr_state_q == W_DATA);
        axi_bvalid_o  = (wr_state_q == W_RESP);
        axi_bid_o     = wr_id_q;
        axi_bresp_o   = ((wr_state_q == W_RESP) && wr_err_q) ? RESP_SLVERR : RESP_OKAY;
        ram_we        = (wr_state_q == W_DATA) && axi_wvalid_i;
    end

    // ----------------------------------------------------------------- read
    rd_state_t                 rd_state_q, rd_state_d;
    logic [AXI_ID_WIDTH-1:0]   rd_id_q, rd_id_d;
    logic [MEM_AWIDTH-1:0]     rd_addr_q, rd_addr_d;
    logic [AXI_LEN_WIDTH-1:0]  rd_cnt_q, rd_cnt_d;
    logic [MEM_AWIDTH-1:0]     rd_addr_nxt;
    logic [MEM_AWIDTH-1:0]     ram_raddr;
    logic                      ram_re;
    logic [AXI_DATA_WIDTH-1:0] ram_rdata;

    assign rd_addr_nxt = rd_addr_q + ADDR_ONE;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_state_q <= R_IDLE;
            rd_id_q    <= '0;
            rd_addr_q  <= '0;
            rd_cnt_q   <= '0;
        end else begin
            rd_state_q <= rd_state_d;
            rd_id_q    <= rd_id_d;
            rd_addr_q  <= rd_addr_d;
            rd_cnt_q   <= rd_cnt_d;
        end
    end

    always_comb begin
        rd_state_d = rd_state_q;
        rd_id_d    = rd_id_q;
        rd_addr_d  = rd_addr_q;
        rd_cnt_d   = rd_cnt_q;
        case (rd_state_q)
            R_IDLE: begin
                if (axi_arvalid_i) begin
                    rd_id_d    = axi_arid_i;
                    rd_addr_d  = axi_araddr_i[MEM_AWIDTH+BS-1:BS];
                    rd_cnt_d   = axi_arlen_i;
                    rd_state_d = R_FETCH;
                end
            end
            R_FETCH: rd_state_d = R_DATA;
            R_DATA: begin
                if (axi_rready_i) begin
                    if (rd_cnt_q == '0) begin
                        rd_state_d = R_IDLE;
                    end else begin
                        rd_addr_d = rd_addr_nxt;
                        rd_cnt_d  = rd_cnt_q - LEN_ONE;
                    end
                end
            end
            default: rd_state_d = R_IDLE;
        endcase
    end

    // The next beat is fetched on the accepting handshake so beats stream back-to-back;
    // with no fetch the RAM output register holds rdata stable under back-pressure.
    always_comb begin
        axi_arready_o = !rst && (rd_state_q == R_IDLE);
        axi_rvalid_o  = (rd_state_q == R_DATA);
        axi_rlast_o   = (rd_state_q == R_DATA) && (rd_cnt_q == '0);
        axi_rid_o     = rd_id_q;
        axi_rresp_o   = RESP_OKAY;
        axi_rdata_o   = ram_rdata;
        ram_raddr     = (rd_state_q == R_IDLE) ? axi_araddr_i[MEM_AWIDTH+BS-1:BS] : rd_addr_nxt;
        ram_re        = ((rd_state_q == R_IDLE) && axi_arvalid_i) ||
                        ((rd_state_q == R_DATA) && axi_rready_i && (rd_cnt_q != '0));
    end

    axis_slave_ram #(
        .MEM_AWIDTH     (MEM_AWIDTH),
        .AXI_DATA_WIDTH (AXI_DATA_WIDTH)
    ) u_ram (
        .clk     (clk),
        .rst     (rst),
        .we_i    (ram_we),
        .waddr_i (wr_addr_q),
        .wdata_i (axi_wdata_i),
        .wstrb_i (axi_wstrb_i),
        .re_i    (ram_re),
        .raddr_i (ram_raddr),
        .rdata_o (ram_rdata)
    );

    logic w_unused;
    assign w_unused = ^{axi_awaddr_i[AXI_ADDR_WIDTH-1:MEM_AWIDTH+BS], axi_awaddr_i[BS-1:0],
                        axi_araddr_i[AXI_ADDR_WIDTH-1:MEM_AWIDTH+BS], axi_araddr_i[BS-1:0]};

endmodule

`default_nettype wire
